// File: rtl/core_ex_lsu_pkg.sv
// core_ex_lsu_pkg
//   Shared definitions for the EX-stage load/store unit.
//   - CORE_XLEN       : datapath width (only 32 is supported)
//   - LSU_SIZE_*      : access size encodings carried on lsu_size
//   - LSU_EXC_*       : exception codes reported on exc_code
//   - lsu_state_e     : FSM state encodings of core_ex_lsu
package core_ex_lsu_pkg;

  localparam int CORE_XLEN = 32;

  localparam logic [1:0] LSU_SIZE_B = 2'b00;
  localparam logic [1:0] LSU_SIZE_H = 2'b01;
  localparam logic [1:0] LSU_SIZE_W = 2'b10;

  localparam logic [1:0] LSU_EXC_NONE     = 2'b00;
  localparam logic [1:0] LSU_EXC_MISALIGN = 2'b01;
  localparam logic [1:0] LSU_EXC_BUSERR   = 2'b10;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'b00,
    LSU_REQ  = 2'b01,
    LSU_WAIT = 2'b10,
    LSU_DONE = 2'b11
  } lsu_state_e;

endpackage

// File: rtl/core_lsu_align.sv
// core_lsu_align
//   Purely combinational alignment helper for the load/store unit.
//   Ports:
//     size        in  2   access size (B/H/W, 11 = reserved)
//     addr_lo     in  2   low address bits of the access
//     is_unsigned in  1   zero-extend loads instead of sign-extend
//     wdata       in  32  store data (rs2)
//     rdata       in  32  raw word returned by memory
//     misaligned  out 1   access cannot be issued (bad alignment or reserved size)
//     wstrb       out 4   byte strobes for a store at this address
//     wdata_lanes out 32  store data replicated across byte lanes
//     rdata_ext   out 32  selected and extended load data
module core_lsu_align
  import core_ex_lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic        misaligned,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata_lanes,
  output logic [31:0] rdata_ext
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Reserved size is reported as misaligned so it never reaches memory.
  always_comb begin
    misaligned = 1'b0;
    case (size)
      LSU_SIZE_B: misaligned = 1'b0;
      LSU_SIZE_H: misaligned = addr_lo[0];
      LSU_SIZE_W: misaligned = (addr_lo != 2'b00);
      default:    misaligned = 1'b1;
    endcase
  end

  always_comb begin
    wstrb = 4'b0000;
    case (size)
      LSU_SIZE_B: wstrb = 4'b0001 << addr_lo;
      LSU_SIZE_H: wstrb = 4'b0011 << addr_lo;
      LSU_SIZE_W: wstrb = 4'b1111;
      default:    wstrb = 4'b0000;
    endcase
  end

  // Each byte lane carries the byte of rs2 that would land there after the
  // strobe is applied: byte ops repeat byte 0, half ops repeat bytes 0/1.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      always_comb begin
        case (size)
          LSU_SIZE_B: wdata_lanes[8*gi +: 8] = wdata[7:0];
          LSU_SIZE_H: wdata_lanes[8*gi +: 8] = wdata[8*(gi%2) +: 8];
          default:    wdata_lanes[8*gi +: 8] = wdata[8*gi +: 8];
        endcase
      end
    end
  endgenerate

  always_comb begin
    byte_sel = rdata[7:0];
    case (addr_lo)
      2'b00: byte_sel = rdata[7:0];
      2'b01: byte_sel = rdata[15:8];
      2'b10: byte_sel = rdata[23:16];
      2'b11: byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
  end

  // Halves are only ever issued at addr_lo = 0 or 2.
  assign half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    rdata_ext = rdata;
    case (size)
      LSU_SIZE_B: rdata_ext = is_unsigned ? {24'b0, byte_sel}
                                          : {{24{byte_sel[7]}}, byte_sel};
      LSU_SIZE_H: rdata_ext = is_unsigned ? {16'b0, half_sel}
                                          : {{16{half_sel[15]}}, half_sel};
      default:    rdata_ext = rdata;
    endcase
  end

endmodule

// File: rtl/core_ex_lsu.sv
// core_ex_lsu
//   Load/store unit behind the EX-stage ALU. Accepts one memory op at a time
//   over a valid/ready handshake, issues one word-aligned request to the data
//   memory port, and returns extended load data or an exception.
//   Ports:
//     clk, rst              clock, asynchronous active-high reset
//     lsu_valid/lsu_ready   EX op handshake (ready only while idle)
//     lsu_is_store, lsu_size, lsu_unsigned, lsu_addr, lsu_wdata, lsu_rd
//                           op description captured on acceptance
//     lsu_flush             kill the in-flight op / block acceptance
//     mem_req_*             request channel (held stable until ready)
//     mem_rsp_*             response channel (data + bus error)
//     wb_valid/wb_rd/wb_data  one-cycle load writeback
//     done                  one-cycle completion pulse
//     exc_valid/exc_code/exc_addr  one-cycle exception report
module core_ex_lsu
  import core_ex_lsu_pkg::*;
#(
  parameter int XLEN = CORE_XLEN,
  parameter int RD_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            lsu_valid,
  output logic            lsu_ready,
  input  logic            lsu_is_store,
  input  logic [1:0]      lsu_size,
  input  logic            lsu_unsigned,
  input  logic [XLEN-1:0] lsu_addr,
  input  logic [XLEN-1:0] lsu_wdata,
  input  logic [RD_W-1:0] lsu_rd,
  input  logic            lsu_flush,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_req_addr,
  output logic            mem_req_we,
  output logic [3:0]      mem_req_wstrb,
  output logic [XLEN-1:0] mem_req_wdata,
  input  logic            mem_rsp_valid,
  input  logic [XLEN-1:0] mem_rsp_rdata,
  input  logic            mem_rsp_err,
  output logic            wb_valid,
  output logic [RD_W-1:0] wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            done,
  output logic            exc_valid,
  output logic [1:0]      exc_code,
  output logic [XLEN-1:0] exc_addr
);

  lsu_state_e state_reg, state_next;

  logic            is_store_reg;
  logic [1:0]      size_reg;
  logic            unsigned_reg;
  logic [XLEN-1:0] addr_reg;
  logic [XLEN-1:0] wdata_reg;
  logic [RD_W-1:0] rd_reg;
  logic [XLEN-1:0] load_data_reg;
  logic            kill_reg, kill_next;
  logic [1:0]      exc_code_reg, exc_code_next;

  logic accept;
  logic rsp_take;

  logic        al_misaligned;
  logic [3:0]  al_wstrb;
  logic [31:0] al_wdata_lanes;
  logic [31:0] al_rdata_ext;
  logic [1:0]  al_size;
  logic [1:0]  al_addr_lo;

  // While idle the aligner checks the op being offered; afterwards it works
  // on the captured op, so a single instance covers all three jobs.
  assign al_size    = (state_reg == LSU_IDLE) ? lsu_size       : size_reg;
  assign al_addr_lo = (state_reg == LSU_IDLE) ? lsu_addr[1:0]  : addr_reg[1:0];

  core_lsu_align u_align (
    .size        (al_size),
    .addr_lo     (al_addr_lo),
    .is_unsigned (unsigned_reg),
    .wdata       (wdata_reg),
    .rdata       (mem_rsp_rdata),
    .misaligned  (al_misaligned),
    .wstrb       (al_wstrb),
    .wdata_lanes (al_wdata_lanes),
    .rdata_ext   (al_rdata_ext)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= LSU_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    accept        = 1'b0;
    rsp_take      = 1'b0;
    kill_next     = kill_reg;
    exc_code_next = exc_code_reg;
    lsu_ready     = 1'b0;
    mem_req_valid = 1'b0;
    done          = 1'b0;
    wb_valid      = 1'b0;
    exc_valid     = 1'b0;
    case (state_reg)
      LSU_IDLE: begin
        lsu_ready = 1'b1;
        kill_next = 1'b0;
        if (lsu_valid && !lsu_flush) begin
          accept = 1'b1;
          if (al_misaligned) begin
            state_next    = LSU_DONE;
            exc_code_next = LSU_EXC_MISALIGN;
          end else begin
            state_next    = LSU_REQ;
            exc_code_next = LSU_EXC_NONE;
          end
        end
      end
      LSU_REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) begin
          // Request already left: a flush now must still drain the response.
          state_next = LSU_WAIT;
          kill_next  = kill_reg | lsu_flush;
        end else if (lsu_flush) begin
          state_next = LSU_IDLE;
        end
      end
      LSU_WAIT: begin
        kill_next = kill_reg | lsu_flush;
        if (mem_rsp_valid) begin
          rsp_take   = 1'b1;
          state_next = LSU_DONE;
          if (mem_rsp_err) begin
            exc_code_next = LSU_EXC_BUSERR;
          end
        end
      end
      LSU_DONE: begin
        state_next = LSU_IDLE;
        if (!kill_reg && !lsu_flush) begin
          done = 1'b1;
          if (exc_code_reg != LSU_EXC_NONE) begin
            exc_valid = 1'b1;
          end else if (!is_store_reg) begin
            wb_valid = 1'b1;
          end
        end
      end
      default: state_next = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      is_store_reg  <= 1'b0;
      size_reg      <= 2'b00;
      unsigned_reg  <= 1'b0;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      rd_reg        <= '0;
      load_data_reg <= '0;
      kill_reg      <= 1'b0;
      exc_code_reg  <= LSU_EXC_NONE;
    end else begin
      kill_reg     <= kill_next;
      exc_code_reg <= exc_code_next;
      if (accept) begin
        is_store_reg <= lsu_is_store;
        size_reg     <= lsu_size;
        unsigned_reg <= lsu_unsigned;
        addr_reg     <= lsu_addr;
        wdata_reg    <= lsu_wdata;
        rd_reg       <= lsu_rd;
      end
      if (rsp_take && !is_store_reg) begin
        load_data_reg <= al_rdata_ext;
      end
    end
  end

  // Side-channel outputs are forced to zero outside the cycle they are valid
  // in, so stale captured values never leak onto the buses.
  assign mem_req_addr  = mem_req_valid ? {addr_reg[XLEN-1:2], 2'b00} : '0;
  assign mem_req_we    = mem_req_valid & is_store_reg;
  assign mem_req_wstrb = (mem_req_valid && is_store_reg) ? al_wstrb : 4'b0000;
  assign mem_req_wdata = (mem_req_valid && is_store_reg) ? al_wdata_lanes : '0;

  assign wb_rd    = wb_valid  ? rd_reg        : '0;
  assign wb_data  = wb_valid  ? load_data_reg : '0;
  assign exc_code = exc_valid ? exc_code_reg  : 2'b00;
  assign exc_addr = exc_valid ? addr_reg      : '0;

endmodule

// File: tb/tb_core_ex_lsu.sv
module tb_core_ex_lsu;

  logic        clk;
  logic        rst;
  logic        lsu_valid;
  logic        lsu_ready;
  logic        lsu_is_store;
  logic [1:0]  lsu_size;
  logic        lsu_unsigned;
  logic [31:0] lsu_addr;
  logic [31:0] lsu_wdata;
  logic [4:0]  lsu_rd;
  logic        lsu_flush;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_req_we;
  logic [3:0]  mem_req_wstrb;
  logic [31:0] mem_req_wdata;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_rdata;
  logic        mem_rsp_err;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        done;
  logic        exc_valid;
  logic [1:0]  exc_code;
  logic [31:0] exc_addr;

  core_ex_lsu #(.XLEN(32), .RD_W(5)) dut (
    .clk           (clk),
    .rst           (rst),
    .lsu_valid     (lsu_valid),
    .lsu_ready     (lsu_ready),
    .lsu_is_store  (lsu_is_store),
    .lsu_size      (lsu_size),
    .lsu_unsigned  (lsu_unsigned),
    .lsu_addr      (lsu_addr),
    .lsu_wdata     (lsu_wdata),
    .lsu_rd        (lsu_rd),
    .lsu_flush     (lsu_flush),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_req_we    (mem_req_we),
    .mem_req_wstrb (mem_req_wstrb),
    .mem_req_wdata (mem_req_wdata),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_rdata (mem_rsp_rdata),
    .mem_rsp_err   (mem_rsp_err),
    .wb_valid      (wb_valid),
    .wb_rd         (wb_rd),
    .wb_data       (wb_data),
    .done          (done),
    .exc_valid     (exc_valid),
    .exc_code      (exc_code),
    .exc_addr      (exc_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Results of the most recent run_op.
  logic        r_req_seen, r_req_we, r_unstable, r_got_done;
  logic [31:0] r_req_addr, r_req_wdata;
  logic [3:0]  r_req_wstrb;
  logic        r_wb_valid, r_exc_valid, r_done_after, r_ready_after;
  logic [4:0]  r_wb_rd;
  logic [31:0] r_wb_data, r_exc_addr;
  logic [1:0]  r_exc_code;
  int          r_latency;

  // Runs one op end-to-end with a responsive memory. Called at a negedge;
  // returns at the negedge after the completion pulse.
  task automatic run_op(input logic st, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [4:0] rd, input logic [31:0] rdata,
                        input logic err, input int stall);
    logic hs_prev;
    int   stall_cnt;
    hs_prev = 1'b0; stall_cnt = 0;
    r_req_seen = 1'b0; r_req_we = 1'b0; r_unstable = 1'b0; r_got_done = 1'b0;
    r_req_addr = '0; r_req_wdata = '0; r_req_wstrb = '0;
    r_wb_valid = 1'b0; r_exc_valid = 1'b0; r_wb_rd = '0; r_wb_data = '0;
    r_exc_addr = '0; r_exc_code = '0; r_latency = 0;
    lsu_valid = 1'b1; lsu_is_store = st; lsu_size = sz; lsu_unsigned = uns;
    lsu_addr = addr; lsu_wdata = wdata; lsu_rd = rd;
    @(negedge clk);
    lsu_valid = 1'b0;
    for (int c = 0; c < 50; c++) begin
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b0;
      mem_rsp_err   = 1'b0;
      if (hs_prev) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = rdata;
        mem_rsp_err   = err;
        hs_prev = 1'b0;
      end
      if (mem_req_valid) begin
        if (!r_req_seen) begin
          r_req_seen  = 1'b1;
          r_req_addr  = mem_req_addr;
          r_req_wdata = mem_req_wdata;
          r_req_wstrb = mem_req_wstrb;
          r_req_we    = mem_req_we;
        end else if (mem_req_addr !== r_req_addr || mem_req_wdata !== r_req_wdata ||
                     mem_req_wstrb !== r_req_wstrb || mem_req_we !== r_req_we) begin
          r_unstable = 1'b1;
        end
        if (lsu_ready) r_unstable = 1'b1;
        if (stall_cnt < stall) begin
          stall_cnt++;
        end else begin
          mem_req_ready = 1'b1;
          hs_prev = 1'b1;
        end
      end
      if (done) begin
        r_got_done  = 1'b1;
        r_latency   = c + 1;
        r_wb_valid  = wb_valid;
        r_wb_rd     = wb_rd;
        r_wb_data   = wb_data;
        r_exc_valid = exc_valid;
        r_exc_code  = exc_code;
        r_exc_addr  = exc_addr;
        break;
      end
      @(negedge clk);
    end
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_err   = 1'b0;
    @(negedge clk);
    r_done_after  = done;
    r_ready_after = lsu_ready;
    $display("op st=%0d sz=%0d addr=%h -> done=%0d lat=%0d wb=%0d data=%h exc=%0d code=%0d",
             st, sz, addr, r_got_done, r_latency, r_wb_valid, r_wb_data, r_exc_valid, r_exc_code);
  endtask

  initial begin
    rst = 1'b1;
    lsu_valid = 1'b0; lsu_is_store = 1'b0; lsu_size = 2'b00; lsu_unsigned = 1'b0;
    lsu_addr = '0; lsu_wdata = '0; lsu_rd = '0; lsu_flush = 1'b0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_rdata = '0; mem_rsp_err = 1'b0;

    // Reset state
    #12;
    check("rst_lsu_ready", {31'b0, lsu_ready}, 32'd1);
    check("rst_req_valid", {31'b0, mem_req_valid}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_wb_valid", {31'b0, wb_valid}, 32'd0);
    check("rst_exc_valid", {31'b0, exc_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // LW 0x100, best case
    run_op(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 5'd7, 32'hDEADBEEF, 1'b0, 0);
    check("lw_req_addr", r_req_addr, 32'h100);
    check("lw_wstrb", {28'b0, r_req_wstrb}, 32'h0);
    check("lw_we", {31'b0, r_req_we}, 32'd0);
    check("lw_latency", r_latency, 32'd3);
    check("lw_wb_valid", {31'b0, r_wb_valid}, 32'd1);
    check("lw_wb_data", r_wb_data, 32'hDEADBEEF);
    check("lw_wb_rd", {27'b0, r_wb_rd}, 32'd7);
    check("lw_done_pulse", {31'b0, r_done_after}, 32'd0);
    check("lw_ready_after", {31'b0, r_ready_after}, 32'd1);

    // LB / LBU 0x103
    run_op(1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 5'd3, 32'h80123456, 1'b0, 0);
    check("lb_req_addr", r_req_addr, 32'h100);
    check("lb_wb_data", r_wb_data, 32'hFFFFFF80);
    run_op(1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 5'd3, 32'h80123456, 1'b0, 0);
    check("lbu_wb_data", r_wb_data, 32'h00000080);

    // SH 0x202
    run_op(1'b1, 2'b01, 1'b0, 32'h202, 32'h0000ABCD, 5'd0, 32'h0, 1'b0, 0);
    check("sh_req_addr", r_req_addr, 32'h200);
    check("sh_wstrb", {28'b0, r_req_wstrb}, 32'hC);
    check("sh_wdata", r_req_wdata, 32'hABCDABCD);
    check("sh_we", {31'b0, r_req_we}, 32'd1);
    check("sh_done", {31'b0, r_got_done}, 32'd1);
    check("sh_wb_valid", {31'b0, r_wb_valid}, 32'd0);

    // SB 0x001
    run_op(1'b1, 2'b00, 1'b0, 32'h001, 32'h12345678, 5'd0, 32'h0, 1'b0, 0);
    check("sb_wstrb", {28'b0, r_req_wstrb}, 32'h2);
    check("sb_wdata", r_req_wdata, 32'h78787878);

    // LW 0x101 misaligned
    run_op(1'b0, 2'b10, 1'b0, 32'h101, 32'h0, 5'd4, 32'h0, 1'b0, 0);
    check("mis_req_seen", {31'b0, r_req_seen}, 32'd0);
    check("mis_latency", r_latency, 32'd1);
    check("mis_exc_valid", {31'b0, r_exc_valid}, 32'd1);
    check("mis_exc_code", {30'b0, r_exc_code}, 32'd1);
    check("mis_exc_addr", r_exc_addr, 32'h101);
    check("mis_wb_valid", {31'b0, r_wb_valid}, 32'd0);

    // Reserved size 11
    run_op(1'b0, 2'b11, 1'b0, 32'h100, 32'h0, 5'd4, 32'h0, 1'b0, 0);
    check("rsv_exc_code", {30'b0, r_exc_code}, 32'd1);

    // LH 0x102 with 3 stall cycles
    run_op(1'b0, 2'b01, 1'b0, 32'h102, 32'h0, 5'd9, 32'h80011234, 1'b0, 3);
    check("stall_stable", {31'b0, r_unstable}, 32'd0);
    check("stall_latency", r_latency, 32'd6);
    check("stall_wb_data", r_wb_data, 32'hFFFF8001);

    // Bus error on load
    run_op(1'b0, 2'b10, 1'b0, 32'h400, 32'h0, 5'd5, 32'h12345678, 1'b1, 0);
    check("berr_exc_valid", {31'b0, r_exc_valid}, 32'd1);
    check("berr_exc_code", {30'b0, r_exc_code}, 32'd2);
    check("berr_exc_addr", r_exc_addr, 32'h400);
    check("berr_wb_valid", {31'b0, r_wb_valid}, 32'd0);

    // Flush in WAIT: response consumed, no pulses
    lsu_valid = 1'b1; lsu_is_store = 1'b0; lsu_size = 2'b10; lsu_addr = 32'h300; lsu_rd = 5'd2;
    @(negedge clk);
    lsu_valid = 1'b0; mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0; lsu_flush = 1'b1;
    @(negedge clk);
    lsu_flush = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'h55AA55AA;
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    check("flw_done", {31'b0, done}, 32'd0);
    check("flw_wb_valid", {31'b0, wb_valid}, 32'd0);
    @(negedge clk);
    check("flw_ready", {31'b0, lsu_ready}, 32'd1);
    $display("op flush-in-wait addr=00000300 -> done suppressed");

    // Flush in REQ before handshake
    lsu_valid = 1'b1; lsu_addr = 32'h500;
    @(negedge clk);
    lsu_valid = 1'b0;
    check("frq_req_valid", {31'b0, mem_req_valid}, 32'd1);
    lsu_flush = 1'b1;
    @(negedge clk);
    lsu_flush = 1'b0;
    check("frq_ready", {31'b0, lsu_ready}, 32'd1);
    check("frq_req_drop", {31'b0, mem_req_valid}, 32'd0);
    check("frq_done", {31'b0, done}, 32'd0);
    $display("op flush-in-req addr=00000500 -> dropped");

    // Flush in IDLE blocks acceptance
    lsu_valid = 1'b1; lsu_flush = 1'b1; lsu_addr = 32'h600;
    @(negedge clk);
    lsu_valid = 1'b0; lsu_flush = 1'b0;
    check("fid_ready", {31'b0, lsu_ready}, 32'd1);
    check("fid_req_valid", {31'b0, mem_req_valid}, 32'd0);
    $display("op flush-in-idle addr=00000600 -> not accepted");

    // Async reset in REQ
    lsu_valid = 1'b1; lsu_addr = 32'h700;
    @(negedge clk);
    lsu_valid = 1'b0;
    check("arst_req_before", {31'b0, mem_req_valid}, 32'd1);
    #1 rst = 1'b1;
    #1;
    check("arst_req_valid", {31'b0, mem_req_valid}, 32'd0);
    check("arst_ready", {31'b0, lsu_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    $display("op reset-in-req addr=00000700 -> abandoned");

    // Recovery after reset
    run_op(1'b0, 2'b01, 1'b1, 32'h800, 32'h0, 5'd1, 32'h1234F00D, 1'b0, 0);
    check("rec_wb_data", r_wb_data, 32'h0000F00D);
    check("rec_wb_valid", {31'b0, r_wb_valid}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/core_ex_lsu.md
Name: core_ex_lsu

Overview:
Load/store unit directly downstream of the EX-stage ALU. It takes the ALU-computed effective address plus the store data (rs2), and issues a single outstanding request to the data-memory port. It returns aligned, sign/zero-extended load data to writeback, or raises a misalignment or bus-error exception. It is multi-cycle and stalls EX through a valid/ready handshake.

Parameters:
XLEN, 32, datapath width (tied to `CORE_XLEN; only 32 supported)
RD_W, 5, destination register index width

Ports:
clk  in  1  core clock
rst  in  1  asynchronous active-high reset
lsu_valid  in  1  EX presents a memory op
lsu_ready  out  1  LSU can accept (IDLE only)
lsu_is_store  in  1  1=store, 0=load
lsu_size  in  2  00=byte, 01=half, 10=word, 11=reserved (treated as misaligned)
lsu_unsigned  in  1  zero-extend load (LBU/LHU)
lsu_addr  in  XLEN  effective address (ALU adder_result)
lsu_wdata  in  XLEN  store data (rs2)
lsu_rd  in  RD_W  load destination
lsu_flush  in  1  kill in-flight op (pipeline flush)
mem_req_valid  out  1  memory request valid
mem_req_ready  in  1  memory accepts request
mem_req_addr  out  XLEN  word-aligned address (addr[1:0]=0)
mem_req_we  out  1  write enable
mem_req_wstrb  out  4  byte strobes
mem_req_wdata  out  XLEN  lane-shifted store data
mem_rsp_valid  in  1  response/ack
mem_rsp_rdata  in  XLEN  raw word read
mem_rsp_err  in  1  bus error with response
wb_valid  out  1  one-cycle load-result pulse
wb_rd  out  RD_W  destination index
wb_data  out  XLEN  extended load data
done  out  1  one-cycle completion pulse (load, store or exception)
exc_valid  out  1  one-cycle exception pulse, coincident with done
exc_code  out  2  01=misaligned, 10=bus error
exc_addr  out  XLEN  original unaligned lsu_addr

Behaviour:
- Reset (async, rst=1): state=IDLE. All outputs are 0 except lsu_ready=1. Captured registers are cleared.
- States: IDLE, REQ, WAIT, DONE.
- IDLE: lsu_ready=1. On lsu_valid&lsu_ready the LSU captures all inputs.
  - Misaligned (half with addr[0]=1, word with addr[1:0]!=0, or size=11): go to DONE with exc code 01. No memory request is issued.
  - Otherwise: go to REQ.
- REQ: mem_req_valid=1. Address, we, wstrb and wdata stay stable until mem_req_ready. On the handshake, go to WAIT.
- WAIT: wait for mem_rsp_valid. On the response, capture the extended load data and the error flag, then go to DONE. Responses arriving in any other state are ignored; memory guarantees the response comes at least 1 cycle after the request handshake.
- DONE: holds for one cycle, then returns to IDLE.
  - done=1.
  - Load without error: wb_valid=1.
  - Exception: exc_valid=1 and wb_valid=0.
- Best-case load/store latency: accept at T0, request at T1 (ready=1), response at T2, done/wb at T3. lsu_ready is therefore low for T1..T3.
- Store strobes: byte → 0001 << addr[1:0]; half → 0011 << addr[1:0]; word → 1111.
- Store data: lsu_wdata replicated into lanes (byte ×4, half ×2).
- Load extract: select the byte/half at addr[1:0], then sign- or zero-extend to XLEN.
- Flush:
  - In REQ before the handshake: drop to IDLE, no done.
  - In WAIT, or in REQ with a same-cycle handshake: set a kill flag, still consume the response, then go DONE→IDLE with done, wb_valid and exc_valid all suppressed.
  - In DONE: suppress the pulses.
  - In IDLE: block acceptance that cycle.
- Simultaneous lsu_valid and lsu_flush in IDLE: the op is not accepted.
- Reset mid-transaction abandons the op. Memory-side cleanup is the memory's responsibility.

Decomposition:
- core_defines.v gains:
  - `CORE_LSU_SIZE_B/H/W encodings
  - `CORE_LSU_EXC_MISALIGN / `CORE_LSU_EXC_BUSERR codes
  - `CORE_LSU_STATE_* encodings
- One combinational sub-module, core_lsu_align: store strobe/lane generation, load extract/extend, and misalign detection. The FSM and registers stay in core_ex_lsu.

Test Plan:
- LW addr=0x100, mem ready immediately, rdata=0xDEADBEEF at T2 → wb_valid at T3, wb_data=0xDEADBEEF, mem_req_addr=0x100, wstrb=0.
- LB addr=0x103, rdata=0x80123456 → wb_data=0xFFFFFF80. Same access as LBU → 0x00000080.
- SH addr=0x202, wdata=0x0000ABCD → mem_req_addr=0x200, wstrb=1100, wdata=0xABCDABCD, done with wb_valid=0.
- LW addr=0x101 → no mem_req_valid, exc_valid=1, exc_code=01, exc_addr=0x101 at T1.
- mem_req_ready low for 3 cycles → addr/wdata/wstrb stable throughout, lsu_ready=0. Load completes normally afterwards.
- lsu_flush asserted in WAIT, then rsp arrives → no wb_valid/done, back in IDLE with lsu_ready=1. Async rst asserted in REQ → mem_req_valid drops immediately, state=IDLE.
